vec_reg_file: RTL and testbench

Parametrised, clocked successor to the vector register bank: NREGS vector registers of N elements × BITS bits, each carrying a length tag and a pending (reserved) bit. It sits between the instruction decoder and the vector ALU. It provides one masked write port, two registered read ports with write-to-read bypass, a register-reservation scoreboard that stalls reads of in-flight results, and a single-cycle global clear.

---
 rtl/vec_reg_file.sv | 186 ++++++++++++++++++
 tb/tb_vec_reg_file.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/vec_reg_file.sv
// vec_reg_file
// Vector register bank that sits between the instruction decoder and the
// vector ALU. It holds NREGS registers of N lanes x BITS bits. Each register
// also carries a length tag and a pending (reserved) bit.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in, in_len, in_mask,       masked write port (write strobe, destination
//   in_sel, write                in_sel, per-lane enable in_mask)
//   rsv, rsv_sel               reservation strobe: marks rsv_sel pending
//   clear                      single-cycle global clear of all state
//   out_sel_a/b, out_en_a/b    read-port source select and enable
//   out_a/b, out_a_len/b_len   registered read data and length tag
//   out_a_valid/b_valid        read data delivered this cycle
//   stall_a/stall_b            read refused because the source is pending
module vec_reg_file #(
    parameter int BITS  = 8,
    parameter int N     = 4,
    parameter int NREGS = 16,
    parameter int LEN_W = 8,
    parameter int SEL_W = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N-1:0][BITS-1:0]   in,
    input  logic [LEN_W-1:0]         in_len,
    input  logic [N-1:0]             in_mask,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     write,
    input  logic                     rsv,
    input  logic [SEL_W-1:0]         rsv_sel,
    input  logic                     clear,
    input  logic [SEL_W-1:0]         out_sel_a,
    input  logic [SEL_W-1:0]         out_sel_b,
    input  logic                     out_en_a,
    input  logic                     out_en_b,
    output logic [N-1:0][BITS-1:0]   out_a,
    output logic [N-1:0][BITS-1:0]   out_b,
    output logic [LEN_W-1:0]         out_a_len,
    output logic [LEN_W-1:0]         out_b_len,
    output logic                     out_a_valid,
    output logic                     out_b_valid,
    output logic                     stall_a,
    output logic                     stall_b
);

    typedef logic [N-1:0][BITS-1:0] vec_t;

    localparam logic [LEN_W-1:0] N_LEN = LEN_W'(N);

    vec_t             data_q [NREGS];
    vec_t             data_d [NREGS];
    logic [LEN_W-1:0] len_q  [NREGS];
    logic [LEN_W-1:0] len_d  [NREGS];
    logic [NREGS-1:0] pend_q, pend_d;

    // Index 0 is port A, index 1 is port B.
    vec_t             rd_data_q [2];
    vec_t             rd_data_d [2];
    logic [LEN_W-1:0] rd_len_q  [2];
    logic [LEN_W-1:0] rd_len_d  [2];
    logic [1:0]       rd_valid_q, rd_valid_d;
    logic [1:0]       rd_stall_q, rd_stall_d;

    logic [SEL_W-1:0] rd_sel   [2];
    logic [1:0]       rd_en;
    vec_t             src_data [2];
    logic [LEN_W-1:0] src_len  [2];
    logic [1:0]       wr_hit;
    logic [LEN_W-1:0] in_len_sat;

    assign rd_sel[0] = out_sel_a;
    assign rd_sel[1] = out_sel_b;
    assign rd_en     = {out_en_b, out_en_a};

    // A length longer than the lane count saturates at N rather than wrapping.
    assign in_len_sat = (in_len > N_LEN) ? N_LEN : in_len;

    // Storage update. Clear beats everything. A reserve is applied after the
    // write so that a simultaneous write and reserve of one register leaves
    // it pending: the reservation belongs to a newer producer.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            data_d[r] = data_q[r];
            len_d[r]  = len_q[r];
        end
        pend_d = pend_q;
        if (clear) begin
            for (int r = 0; r < NREGS; r++) begin
                data_d[r] = '0;
                len_d[r]  = '0;
            end
            pend_d = '0;
        end else begin
            if (write) begin
                for (int i = 0; i < N; i++) begin
                    if (in_mask[i]) begin
                        data_d[in_sel][i] = in[i];
                    end
                end
                len_d[in_sel]  = in_len_sat;
                pend_d[in_sel] = 1'b0;
            end
            if (rsv) begin
                pend_d[rsv_sel] = 1'b1;
            end
        end
    end

    // Read ports. The source is the stored register merged with the
    // in-flight write when it targets the same register. A pending source
    // stalls unless this very write resolves it. Lanes at or beyond the
    // delivered length read as zero. A stalled or idle port keeps its last
    // data and length.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data_d[p]  = rd_data_q[p];
            rd_len_d[p]   = rd_len_q[p];
            rd_valid_d[p] = 1'b0;
            rd_stall_d[p] = 1'b0;
            wr_hit[p]     = write && (in_sel == rd_sel[p]);
            src_data[p]   = data_q[rd_sel[p]];
            src_len[p]    = len_q[rd_sel[p]];
            if (wr_hit[p]) begin
                for (int i = 0; i < N; i++) begin
                    if (in_mask[i]) begin
                        src_data[p][i] = in[i];
                    end
                end
                src_len[p] = in_len_sat;
            end
            if (clear) begin
                rd_data_d[p] = '0;
                rd_len_d[p]  = '0;
            end else if (rd_en[p]) begin
                if (pend_q[rd_sel[p]] && !wr_hit[p]) begin
                    rd_stall_d[p] = 1'b1;
                end else begin
                    for (int i = 0; i < N; i++) begin
                        rd_data_d[p][i] = (i < int'(src_len[p])) ? src_data[p][i] : '0;
                    end
                    rd_len_d[p]   = src_len[p];
                    rd_valid_d[p] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                data_q[r] <= '0;
                len_q[r]  <= '0;
            end
            pend_q <= '0;
            for (int p = 0; p < 2; p++) begin
                rd_data_q[p] <= '0;
                rd_len_q[p]  <= '0;
            end
            rd_valid_q <= '0;
            rd_stall_q <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                data_q[r] <= data_d[r];
                len_q[r]  <= len_d[r];
            end
            pend_q <= pend_d;
            for (int p = 0; p < 2; p++) begin
                rd_data_q[p] <= rd_data_d[p];
                rd_len_q[p]  <= rd_len_d[p];
            end
            rd_valid_q <= rd_valid_d;
            rd_stall_q <= rd_stall_d;
        end
    end

    assign out_a       = rd_data_q[0];
    assign out_b       = rd_data_q[1];
    assign out_a_len   = rd_len_q[0];
    assign out_b_len   = rd_len_q[1];
    assign out_a_valid = rd_valid_q[0];
    assign out_b_valid = rd_valid_q[1];
    assign stall_a     = rd_stall_q[0];
    assign stall_b     = rd_stall_q[1];

endmodule

// File: tb/tb_vec_reg_file.sv
// tb_vec_reg_file
// Directed testbench for vec_reg_file with default parameters
// (BITS=8, N=4, NREGS=16, LEN_W=8). Vectors are written as 32-bit words,
// with lane 0 in the low byte.
module tb_vec_reg_file;

    logic                clk;
    logic                rst_n;
    logic [3:0][7:0]     in;
    logic [7:0]          in_len;
    logic [3:0]          in_mask;
    logic [3:0]          in_sel;
    logic                write;
    logic                rsv;
    logic [3:0]          rsv_sel;
    logic                clear;
    logic [3:0]          out_sel_a, out_sel_b;
    logic                out_en_a, out_en_b;
    logic [3:0][7:0]     out_a, out_b;
    logic [7:0]          out_a_len, out_b_len;
    logic                out_a_valid, out_b_valid;
    logic                stall_a, stall_b;

    int checks_total  = 0;
    int checks_passed = 0;

    vec_reg_file #(.BITS(8), .N(4), .NREGS(16), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in(in), .in_len(in_len), .in_mask(in_mask), .in_sel(in_sel),
        .write(write), .rsv(rsv), .rsv_sel(rsv_sel), .clear(clear),
        .out_sel_a(out_sel_a), .out_sel_b(out_sel_b),
        .out_en_a(out_en_a), .out_en_b(out_en_b),
        .out_a(out_a), .out_b(out_b),
        .out_a_len(out_a_len), .out_b_len(out_b_len),
        .out_a_valid(out_a_valid), .out_b_valid(out_b_valid),
        .stall_a(stall_a), .stall_b(stall_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks_total++;
        if (observed !== expected)
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        else
            checks_passed++;
    endtask

    task automatic checkPort(input string tag, input int port, input logic [31:0] data,
                             input logic [7:0] len, input logic valid, input logic stall);
        if (port == 0) begin
            checkOutput({tag, ".a_data"},  64'(out_a),       64'(data));
            checkOutput({tag, ".a_len"},   64'(out_a_len),   64'(len));
            checkOutput({tag, ".a_valid"}, 64'(out_a_valid), 64'(valid));
            checkOutput({tag, ".a_stall"}, 64'(stall_a),     64'(stall));
        end else begin
            checkOutput({tag, ".b_data"},  64'(out_b),       64'(data));
            checkOutput({tag, ".b_len"},   64'(out_b_len),   64'(len));
            checkOutput({tag, ".b_valid"}, 64'(out_b_valid), 64'(valid));
            checkOutput({tag, ".b_stall"}, 64'(stall_b),     64'(stall));
        end
    endtask

    task automatic driveInputs(input logic w, input logic [3:0] wsel, input logic [31:0] wdata,
                               input logic [7:0] wlen, input logic [3:0] wmask,
                               input logic r, input logic [3:0] rsel, input logic clr,
                               input logic ena, input logic [3:0] sela,
                               input logic enb, input logic [3:0] selb);
        write     = w;
        in_sel    = wsel;
        in        = wdata;
        in_len    = wlen;
        in_mask   = wmask;
        rsv       = r;
        rsv_sel   = rsel;
        clear     = clr;
        out_en_a  = ena;
        out_sel_a = sela;
        out_en_b  = enb;
        out_sel_b = selb;
    endtask

    // Drive one cycle of inputs, then land just after the next rising edge.
    task automatic applyStimulus(input logic w, input logic [3:0] wsel, input logic [31:0] wdata,
                                 input logic [7:0] wlen, input logic [3:0] wmask,
                                 input logic r, input logic [3:0] rsel, input logic clr,
                                 input logic ena, input logic [3:0] sela,
                                 input logic enb, input logic [3:0] selb);
        driveInputs(w, wsel, wdata, wlen, wmask, r, rsel, clr, ena, sela, enb, selb);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        driveInputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        checkPort("reset", 0, 32'h0, 8'd0, 0, 0);
        checkPort("reset", 1, 32'h0, 8'd0, 0, 0);
        rst_n = 1'b1;

        // Basic write then read; lanes 2 and 3 are masked by len 2.
        applyStimulus(1, 0, 32'h66553C0F, 8'd2, 4'hF, 0, 0, 0, 0, 0, 0, 0);
        checkPort("wr0_idle", 0, 32'h0, 8'd0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        checkPort("rd0", 0, 32'h00003C0F, 8'd2, 1, 0);

        // Masked write over reg1.
        applyStimulus(1, 1, 32'h007D7EFF, 8'd3, 4'hF, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 32'h44332211, 8'd4, 4'b0101, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        checkPort("mask_rd1", 0, 32'h00337E11, 8'd4, 1, 0);

        // Length saturation, seen through bypass and then from storage.
        applyStimulus(1, 1, 32'hFFFFFFFF, 8'd9, 4'b0000, 0, 0, 0, 0, 0, 1, 1);
        checkPort("sat_bypass", 1, 32'h00337E11, 8'd4, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        checkPort("sat_stored", 0, 32'h00337E11, 8'd4, 1, 0);

        // Lane masking with len 1.
        applyStimulus(1, 5, 32'hDDCCBBAA, 8'd1, 4'hF, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0);
        checkPort("len1_rd5", 0, 32'h000000AA, 8'd1, 1, 0);

        // Bypass on both ports at once.
        applyStimulus(1, 2, 32'h00000001, 8'd2, 4'hF, 0, 0, 0, 1, 2, 1, 2);
        checkPort("byp_both", 0, 32'h00000001, 8'd2, 1, 0);
        checkPort("byp_both", 1, 32'h00000001, 8'd2, 1, 0);

        // Partial-mask bypass on B while A is disabled and holds.
        applyStimulus(1, 1, 32'h0000AB00, 8'd4, 4'b0010, 0, 0, 0, 0, 0, 1, 1);
        checkPort("byp_mask", 1, 32'h0033AB11, 8'd4, 1, 0);
        checkPort("a_hold", 0, 32'h00000001, 8'd2, 0, 0);

        // Scoreboard: reserve reg3, then a read of it stalls and holds.
        applyStimulus(0, 0, 0, 0, 0, 1, 3, 0, 1, 2, 0, 0);
        checkPort("rsv_rd2", 0, 32'h00000001, 8'd2, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        checkPort("stall3", 0, 32'h00000001, 8'd2, 0, 1);
        applyStimulus(1, 3, 32'hDDCCBBAA, 8'd4, 4'hF, 0, 0, 0, 1, 3, 0, 0);
        checkPort("reissue3", 0, 32'hDDCCBBAA, 8'd4, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        checkPort("rd3_free", 0, 32'hDDCCBBAA, 8'd4, 1, 0);

        // Write and reserve of reg3 together leave it pending.
        applyStimulus(1, 3, 32'h11111111, 8'd4, 4'hF, 1, 3, 0, 0, 0, 1, 3);
        checkPort("wr_rsv3", 1, 32'h11111111, 8'd4, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        checkPort("still_pend3", 0, 32'hDDCCBBAA, 8'd4, 0, 1);

        // A read in the same cycle as the reserve does not stall.
        applyStimulus(0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 1, 6);
        checkPort("rsv6_same", 1, 32'h0, 8'd0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6);
        checkPort("rsv6_next", 1, 32'h0, 8'd0, 0, 1);

        // Clear overrides the write to reg4 and the reads.
        applyStimulus(1, 4, 32'h55555555, 8'd4, 4'hF, 0, 0, 1, 1, 1, 1, 4);
        checkPort("clear", 0, 32'h0, 8'd0, 0, 0);
        checkPort("clear", 1, 32'h0, 8'd0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 4);
        checkPort("clr_rd0", 0, 32'h0, 8'd0, 1, 0);
        checkPort("clr_rd4", 1, 32'h0, 8'd0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 1, 3);
        checkPort("clr_pend6", 0, 32'h0, 8'd0, 1, 0);
        checkPort("clr_pend3", 1, 32'h0, 8'd0, 1, 0);

        // Async reset in the middle of a write burst.
        applyStimulus(1, 7, 32'hCAFEF00D, 8'd4, 4'hF, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 8, 32'h12345678, 8'd4, 4'hF, 0, 0, 0, 1, 7, 1, 8);
        checkPort("pre_rst", 0, 32'hCAFEF00D, 8'd4, 1, 0);
        checkPort("pre_rst", 1, 32'h12345678, 8'd4, 1, 0);
        driveInputs(1, 9, 32'h9ABCDEF0, 8'd4, 4'hF, 0, 0, 0, 1, 7, 1, 8);
        #3;
        rst_n = 1'b0;
        #1;
        checkPort("mid_rst", 0, 32'h0, 8'd0, 0, 0);
        checkPort("mid_rst", 1, 32'h0, 8'd0, 0, 0);
        @(posedge clk);
        #1;
        checkPort("rst_held", 0, 32'h0, 8'd0, 0, 0);
        driveInputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b1;
        for (int r = 0; r < 16; r++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 4'(r), 1, 4'(15 - r));
            checkPort($sformatf("post_rst%0d", r), 0, 32'h0, 8'd0, 1, 0);
            checkOutput($sformatf("post_rst%0d.b_valid", r), 64'(out_b_valid), 64'd1);
            checkOutput($sformatf("post_rst%0d.b_data", r), 64'(out_b), 64'd0);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
